// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: out = in1 - in2 - borrowIn, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             borrowIn,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrowOut
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  function automatic logic fs_diff(input logic a, input logic b, input logic bor);
    return a ^ b ^ bor;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic bor);
    return (~a & b) | (~(a ^ b) & bor);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_bor;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_bout;
  logic             w_d;
  logic             w_bor_nxt;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_shift;

  assign w_d         = fs_diff(r_a[0], r_b[0], r_bor);
  assign w_bor_nxt   = fs_borrow(r_a[0], r_b[0], r_bor);
  assign w_res_shift = {w_d, r_res};

  assign ready     = (r_state == S_IDLE);
  assign done      = r_done;
  assign out       = r_out;
  assign borrowOut = r_bout;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_BUSY;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_IDLE;
          w_last      = 1'b1;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand shift registers, borrow FF, partial result and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_bor <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= in1;
      r_b   <= in2;
      r_bor <= borrowIn;
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= w_res_shift[WIDTH-1:1];
      r_bor <= w_bor_nxt;
      r_cnt <= r_cnt + ONE_CNT;
    end
  end

  // Result registers; they hold the previous answer until the last bit lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
      r_out  <= '0;
      r_bout <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_out  <= w_res_shift;
        r_bout <= w_bor_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  assign overflow = r_ovf;

  // Operand sign bits are lost to shifting, so they are kept aside for the overflow term
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_msb <= in1[WIDTH-1];
        r_b_msb <= in2[WIDTH-1];
      end
      if (w_last) begin
        r_ovf <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
      end
    end
  end
`endif

endmodule
